// File: rtl/ifetch_unit.sv
// Instruction-fetch reader: takes the PC, reads one word from instruction memory
// over a req/ack bus and latches it into the instruction register.
module ifetch_unit #(
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  // 33-bit so that a range ending at the top of the address space cannot overflow.
  localparam logic [32:0] ImemLast = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4 - 33'd1;

  typedef enum logic [1:0] {StIdle, StBus, StDone, StFault} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            misaligned;
  logic            out_of_range;

  assign misaligned   = |pc[1:0];
  assign out_of_range = (pc < IMEM_BASE) || ({1'b0, pc} > ImemLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      fetch_done <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (flush) begin
      // Abort wins over any same-cycle ack; ir deliberately keeps its value.
      state_q    <= StIdle;
      cnt_q      <= '0;
      imem_req   <= 1'b0;
      ir_valid   <= 1'b0;
      fetch_done <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      fetch_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fetch_req) begin
            ir_valid <= 1'b0;
            if (misaligned) begin
              fault      <= 1'b1;
              fault_code <= 2'b01;
              state_q    <= StFault;
            end else if (out_of_range) begin
              fault      <= 1'b1;
              fault_code <= 2'b10;
              state_q    <= StFault;
            end else begin
              imem_addr <= pc;
              cnt_q     <= '0;
              imem_req  <= 1'b1;
              state_q   <= StBus;
            end
          end
        end
        StBus: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (imem_err) begin
              fault      <= 1'b1;
              fault_code <= 2'b11;
              state_q    <= StFault;
            end else begin
              ir         <= imem_rdata;
              ir_valid   <= 1'b1;
              fetch_done <= 1'b1;
              state_q    <= StDone;
            end
          end else if (cnt_q == CntMax) begin
            imem_req   <= 1'b0;
            fault      <= 1'b1;
            fault_code <= 2'b11;
            state_q    <= StFault;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
